pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 199 +++++++++++++++++++
 tb/tb_pipe_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready register pipeline of DEPTH stages.
// Each stage holds one item (valid bit + WIDTH data register). An item moves
// forward whenever the stage ahead of it is empty or moving too, so bubbles
// collapse even while the consumer is stalled.
//
// Optional feature: define PIPE_REG_SKID_EN to add a 2-entry output buffer
// behind the last stage. The last stage then hands off based on the buffer's
// registered fill level, so out_ready has no combinational path to in_ready.
// This adds one cycle of latency and two items of capacity.
module pipe_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+3)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 3);

    // Per-stage state
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] stage_in [DEPTH];

    // adv[i]: stage i can take a new item (or become empty) at this edge.
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;

    logic             in_hs;
    logic             out_hs;
    // last_go: the last stage may hand its item downstream at this edge.
    logic             last_go;
    // Items held outside the stage chain (skid buffer fill level).
    logic [1:0]       buf_cnt;
    logic [OCC_W-1:0] occ_sum;

    // Advance chain, resolved from the output end back to the input.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !valid_q[DEPTH-1] || last_go;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = !valid_q[i] || adv[i+1];
        end
    end

    // Upstream handshake; blocked during flush and while reset is held.
    assign in_ready = adv[0] && !flush && !rst;
    assign in_hs    = in_valid && in_ready;

    // Source of the data entering each stage.
    always_comb begin
        stage_in[0] = in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_in[i] = data_q[i-1];
        end
    end

    // Next valid bits and data-load enables; a flush empties every stage
    // and freezes the data registers.
    always_comb begin
        valid_d = valid_q;
        load    = '0;
        if (adv[0]) begin
            valid_d[0] = in_hs;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (adv[i]) begin
                valid_d[i] = valid_q[i-1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            load[i] = adv[i] && valid_d[i];
        end
        if (flush) begin
            valid_d = '0;
            load    = '0;
        end
    end

    // Stage valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Stage data registers: load only when an item actually enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (load[i]) begin
                    data_q[i] <= stage_in[i];
                end
            end
        end
    end

`ifdef PIPE_REG_SKID_EN
    // Two-entry output buffer: head drives the output, tail catches the item
    // that arrives while the head is stalled.
    logic [1:0]       buf_cnt_q;
    logic [1:0]       buf_cnt_d;
    logic [WIDTH-1:0] buf_head_q;
    logic [WIDTH-1:0] buf_head_d;
    logic [WIDTH-1:0] buf_tail_q;
    logic [WIDTH-1:0] buf_tail_d;
    logic             buf_push;
    logic             buf_pop;

    // Registered fill level only: keeps out_ready off the in_ready path.
    assign last_go   = (buf_cnt_q != 2'd2);
    assign buf_push  = valid_q[DEPTH-1] && last_go && !flush;
    assign out_valid = (buf_cnt_q != 2'd0) && !flush;
    assign out_hs    = out_valid && out_ready;
    assign buf_pop   = out_hs;
    assign out_data  = buf_head_q;
    assign buf_cnt   = buf_cnt_q;

    // Buffer next state; a push never meets a full buffer.
    always_comb begin
        buf_cnt_d  = buf_cnt_q;
        buf_head_d = buf_head_q;
        buf_tail_d = buf_tail_q;
        case ({buf_push, buf_pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf_head_d = data_q[DEPTH-1];
                end else begin
                    buf_tail_d = data_q[DEPTH-1];
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                if (buf_cnt_q == 2'd2) begin
                    buf_head_d = buf_tail_q;
                end
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with exactly one entry: replace the head.
                buf_head_d = data_q[DEPTH-1];
            end
            default: begin
            end
        endcase
        if (flush) begin
            buf_cnt_d = 2'd0;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt_q  <= 2'd0;
            buf_head_q <= RST_VAL;
            buf_tail_q <= RST_VAL;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            buf_head_q <= buf_head_d;
            buf_tail_q <= buf_tail_d;
        end
    end
`else
    // Output taken straight from the last stage.
    assign out_valid = valid_q[DEPTH-1] && !flush;
    assign out_hs    = out_valid && out_ready;
    assign last_go   = out_hs;
    assign out_data  = data_q[DEPTH-1];
    assign buf_cnt   = 2'd0;
`endif

    // Occupancy: population count of every held item.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[i]);
        end
        occ_sum = occ_sum + OCC_W'(buf_cnt);
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: random and directed stimulus for pipe_reg, checked against a
// queue-based reference model. Handles both builds via PIPE_REG_SKID_EN.
module tb_pipe_reg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 3);
`ifdef PIPE_REG_SKID_EN
    localparam int LAT  = DEPTH + 1;
    localparam int CAP  = DEPTH + 2;
    localparam bit SKID = 1'b1;
`else
    localparam int LAT  = DEPTH;
    localparam int CAP  = DEPTH;
    localparam bit SKID = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    pipe_reg #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: items in acceptance order with their acceptance edge.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               acc;
    } item_t;
    item_t q[$];
    int    edge_n    = 0;   // index of the next rising edge
    int    last_exit = 0;   // edge at which the previous head left

    // DUT values observed in the most recent cycle
    logic             obs_ir;
    logic             obs_ov;
    logic [OCC_W-1:0] obs_occ;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // The head item reaches the output LAT edges after acceptance, but never
    // before its predecessor has left.
    function automatic bit head_visible();
        int ready_edge;
        if (q.size() == 0) return 1'b0;
        ready_edge = q[0].acc + LAT - 1;
        if (last_exit > ready_edge) ready_edge = last_exit;
        return edge_n > ready_edge;
    endfunction

    // One clock cycle: apply inputs, check outputs against the model, clock,
    // then advance the model.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic ordy, input logic fl);
        logic vis;
        logic exp_ir;
        logic ihs;
        logic ohs;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        vis = !fl && head_visible();
        if (SKID) exp_ir = !fl && (q.size() < CAP);
        else      exp_ir = !fl && ((q.size() < DEPTH) || (vis && ordy));
        obs_ir  = in_ready;
        obs_ov  = out_valid;
        obs_occ = occupancy;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("out_valid", 32'(out_valid), 32'(vis));
        check_eq("occupancy", 32'(occupancy), 32'(q.size()));
        if (vis) check_eq("out_data", 32'(out_data), 32'(q[0].data));
        ihs = v && exp_ir;
        ohs = vis && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
            last_exit = 0;
        end else begin
            if (ohs) begin
                void'(q.pop_front());
                last_exit = edge_n;
            end
            if (ihs) q.push_back('{data: d, acc: edge_n});
        end
        edge_n++;
        #1;
    endtask

    // Drain with out_ready=1, bounded.
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check_eq("drain_empty", 32'(occupancy), 32'd0);
    endtask

    // Push one item into an idle pipeline and measure its latency.
    task automatic latency_probe(input string tag, input logic [WIDTH-1:0] d);
        int acc_edge;
        int seen = 99;
        acc_edge = edge_n;
        cycle(1'b1, d, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (obs_ov && seen == 99) seen = edge_n - 1 - acc_edge;
        end
        check_eq(tag, 32'(seen), 32'(LAT));
    endtask

    initial begin
        int acc_cnt;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single item latency
        latency_probe("latency_a5", 8'hA5);
        check_eq("single_occ_zero", 32'(occupancy), 32'd0);

        // Back-to-back stream with out_ready held high
        acc_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            acc_cnt += int'(obs_ir);
        end
        check_eq("stream_accepts", 32'(acc_cnt), 32'd16);
        drain();

        // Continuous push against a stalled consumer
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
            acc_cnt += int'(obs_ir);
        end
        check_eq("stall_accepts", 32'(acc_cnt), 32'(CAP));
        check_eq("stall_occ", 32'(obs_occ), 32'(CAP));
        check_eq("stall_in_ready", 32'(obs_ir), 32'd0);
        check_eq("stall_head", 32'(out_data), 32'h20);
        drain();

        // Gapped pushes while stalled: bubbles collapse
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("gap_fill_occ", 32'(obs_occ), 32'(DEPTH));
        drain();

        // Flush with two items in flight, then a fresh item
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_occ", 32'(occupancy), 32'd0);
        latency_probe("latency_55", 8'h55);

        // Asynchronous reset pulse mid-stream
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_data", 32'(out_data), 32'h00);
        check_eq("arst_occ", 32'(occupancy), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        last_exit = 0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        latency_probe("latency_post_rst", 8'h77);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(3, 0) != 0), 8'($urandom),
                  ($urandom_range(1, 0) != 0), ($urandom_range(31, 0) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
